// File: rtl/servo_pkg.sv
// Shared types and elaboration helpers for the servo shot sequencer.
package servo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        HOLD = 2'd2,
        REST = 2'd3
    } state_e;

    function automatic int tick_div(input int clk_hz);
        return clk_hz / 1_000_000;
    endfunction

    // Bits needed to count 0..n-1; never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo channel: trigger synchroniser, optional debounce (DEBOUNCE_EN),
// falling-edge detector, FIRE/HOLD/REST sequencer with registered outputs.
module servo_channel
    import servo_pkg::*;
#(
    parameter int FRAME_US    = 20000,
    parameter int FIRE_US     = 1800,
    parameter int REST_US     = 1000,
    parameter int FIRE_FRAMES = 100,
    parameter int HOLD_FRAMES = 100,
    parameter int REST_FRAMES = 100,
    parameter int DEBOUNCE_US = 5000
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic trigger,
    output logic pwm,
    output logic busy,
    output logic done
);

    localparam int US_W = cnt_width(FRAME_US);
    localparam int FR_W = cnt_width(max3(FIRE_FRAMES, HOLD_FRAMES, REST_FRAMES));
    localparam logic [US_W-1:0] US_LAST  = US_W'(FRAME_US - 1);
    localparam logic [US_W-1:0] FIRE_LIM = US_W'(FIRE_US);
    localparam logic [US_W-1:0] REST_LIM = US_W'(REST_US);

    if (DEBOUNCE_US < 1) begin : g_db_chk
        $error("DEBOUNCE_US must be at least 1");
    end

    logic sync1_q, sync2_q, lvl_prev_q, fall_q;
    logic level_s, fall_d;
    state_e state_q, state_d;
    logic [US_W-1:0] us_cnt_q, us_cnt_d;
    logic [FR_W-1:0] frame_cnt_q, frame_cnt_d, frame_last_s;
    logic pwm_q, pwm_d, busy_q, busy_d, done_q, done_d;

`ifdef DEBOUNCE_EN
    localparam int DB_W = cnt_width(DEBOUNCE_US);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_US - 1);
    logic filt_q, filt_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;

    // Filtered level flips only after DEBOUNCE_US consecutive disagreeing ticks.
    always_comb begin
        filt_d   = filt_q;
        db_cnt_d = db_cnt_q;
        if (sync2_q == filt_q) begin
            db_cnt_d = '0;
        end else if (tick) begin
            if (db_cnt_q == DB_LAST) begin
                filt_d   = sync2_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end else begin
            db_cnt_d = db_cnt_q;
        end
    end

    // Debounce state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            filt_q   <= 1'b1;
            db_cnt_q <= '0;
        end else begin
            filt_q   <= filt_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign level_s = filt_q;
`else
    assign level_s = sync2_q;
`endif

    assign fall_d = lvl_prev_q & ~level_s;

    // Frame count that closes the current phase.
    always_comb begin
        case (state_q)
            FIRE:    frame_last_s = FR_W'(FIRE_FRAMES - 1);
            HOLD:    frame_last_s = FR_W'(HOLD_FRAMES - 1);
            REST:    frame_last_s = FR_W'(REST_FRAMES - 1);
            default: frame_last_s = '0;
        endcase
    end

    // Sequencer next state; outputs derive from next-state values so pwm stays registered.
    always_comb begin
        state_d     = state_q;
        us_cnt_d    = us_cnt_q;
        frame_cnt_d = frame_cnt_q;
        if (state_q == IDLE) begin
            if (fall_q) begin
                state_d     = FIRE;
                us_cnt_d    = '0;
                frame_cnt_d = '0;
            end else begin
                state_d = IDLE;
            end
        end else if (tick) begin
            if (us_cnt_q == US_LAST) begin
                us_cnt_d = '0;
                if (frame_cnt_q == frame_last_s) begin
                    frame_cnt_d = '0;
                    case (state_q)
                        FIRE:    state_d = HOLD;
                        HOLD:    state_d = REST;
                        REST:    state_d = IDLE;
                        default: state_d = IDLE;
                    endcase
                end else begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end else begin
                us_cnt_d = us_cnt_q + 1'b1;
            end
        end else begin
            state_d = state_q;
        end

        case (state_d)
            FIRE:    pwm_d = (us_cnt_d < FIRE_LIM);
            REST:    pwm_d = (us_cnt_d < REST_LIM);
            default: pwm_d = 1'b0;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_q == REST) && (state_d == IDLE);
    end

    // Synchroniser, edge detector, sequencer and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            lvl_prev_q  <= 1'b1;
            fall_q      <= 1'b0;
            state_q     <= IDLE;
            us_cnt_q    <= '0;
            frame_cnt_q <= '0;
            pwm_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            sync1_q     <= trigger;
            sync2_q     <= sync1_q;
            lvl_prev_q  <= level_s;
            fall_q      <= fall_d;
            state_q     <= state_d;
            us_cnt_q    <= us_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            pwm_q       <= pwm_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign pwm  = pwm_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: rtl/servo_shot_sequencer.sv
// Multi-channel servo shot sequencer: shared 1 us prescaler feeding NUM_CH
// independent channels. Optional trigger debounce enabled by DEBOUNCE_EN.
module servo_shot_sequencer
    import servo_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int NUM_CH      = 2,
    parameter int FRAME_US    = 20000,
    parameter int FIRE_US     = 1800,
    parameter int REST_US     = 1000,
    parameter int FIRE_FRAMES = 100,
    parameter int HOLD_FRAMES = 100,
    parameter int REST_FRAMES = 100,
    parameter int DEBOUNCE_US = 5000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] trigger,
    output logic [NUM_CH-1:0] pwm,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] done
);

    localparam int DIV  = tick_div(CLK_HZ);
    localparam int PS_W = cnt_width(DIV);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);

    if ((CLK_HZ % 1_000_000) != 0 || DIV < 1) begin : g_clk_chk
        $error("CLK_HZ must be a non-zero multiple of 1 MHz");
    end
    if (FIRE_US >= FRAME_US || REST_US >= FRAME_US) begin : g_us_chk
        $error("pulse high time must be shorter than the frame");
    end
    if (FIRE_FRAMES < 1 || HOLD_FRAMES < 1 || REST_FRAMES < 1) begin : g_fr_chk
        $error("frame counts must be non-zero");
    end

    logic [PS_W-1:0] presc_q, presc_d;
    logic tick_s;

    assign tick_s = (presc_q == PS_LAST);

    // Prescaler wrap.
    always_comb begin
        if (tick_s) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    // Free-running prescaler register.
    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        servo_channel #(
            .FRAME_US    (FRAME_US),
            .FIRE_US     (FIRE_US),
            .REST_US     (REST_US),
            .FIRE_FRAMES (FIRE_FRAMES),
            .HOLD_FRAMES (HOLD_FRAMES),
            .REST_FRAMES (REST_FRAMES),
            .DEBOUNCE_US (DEBOUNCE_US)
        ) u_ch (
            .clock   (clock),
            .reset   (reset),
            .tick    (tick_s),
            .trigger (trigger[g]),
            .pwm     (pwm[g]),
            .busy    (busy[g]),
            .done    (done[g])
        );
    end

endmodule
